// File: rtl/uart_tx_dev_if.sv
// Bridge device-side bus for the UART transmitter: address, lane enables,
// write data, combinational read data and the interrupt line.
interface uart_tx_dev_if;
  logic [31:0] Addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        HWInt;

  modport master (output Addr, output byteen, output wdata,
                  input rdata, input HWInt);
  modport slave  (input Addr, input byteen, input wdata,
                  output rdata, output HWInt);
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with DATA/CTRL/STATUS/DIVISOR registers
// and a maskable completion interrupt.
// Optional macro UART_TX_PARITY_EN adds CTRL[2] PEN / CTRL[3] PODD and a
// parity bit between the data bits and the stop bit.
module uart_tx_dev #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_dev_if.slave  bus,
  output logic          TxD
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_PARITY, S_STOP} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

  state_t               r_state, w_state_next;
  logic [7:0]           r_data;
  logic                 r_en, r_im, r_done;
  logic [DIV_WIDTH-1:0] r_divisor;   // programmable divisor (CPU visible)
  logic [DIV_WIDTH-1:0] r_div;       // divisor latched for the frame in flight
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [2:0]           r_idx, w_idx_next;
  logic                 r_txd, w_txd_next;

  logic [1:0]           w_sel;
  logic                 w_accept, w_ctrl_wr, w_w1c, w_tick, w_frame_done;
  logic [DIV_WIDTH-1:0] w_div_mask, w_div_eff;
  logic                 w_par_en, w_par_bit;
  logic [31:0]          w_div32;
  logic [3:0]           w_ctrl_rd;

  assign w_sel     = bus.Addr[3:2];
  assign w_accept  = (w_sel == 2'd0) && bus.byteen[0] && r_en && (r_state == S_IDLE);
  assign w_ctrl_wr = (w_sel == 2'd1) && bus.byteen[0];
  assign w_w1c     = (w_sel == 2'd2) && bus.byteen[0] && bus.wdata[1];
  assign w_tick    = (r_cnt == '0);
  // A programmed divisor of 0 behaves as 1 cycle per bit.
  assign w_div_eff = (r_divisor == '0) ? DIV_ONE : r_divisor;

  // Per-bit write mask for DIVISOR, derived from the lane that owns each bit.
  for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_div_mask
    assign w_div_mask[gi] = (w_sel == 2'd3) && bus.byteen[gi/8];
  end

`ifdef UART_TX_PARITY_EN
  logic r_pen, r_podd, r_pen_lat, r_podd_lat;
  assign w_par_en  = r_pen_lat;
  assign w_par_bit = (^r_data) ^ r_podd_lat;
  assign w_ctrl_rd = {r_podd, r_pen, r_im, r_en};

  // Parity controls: CPU-visible copy plus the copy latched at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pen      <= 1'b0;
      r_podd     <= 1'b0;
      r_pen_lat  <= 1'b0;
      r_podd_lat <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_pen  <= bus.wdata[2];
        r_podd <= bus.wdata[3];
      end
      if (w_accept) begin
        r_pen_lat  <= r_pen;
        r_podd_lat <= r_podd;
      end
    end
  end
`else
  assign w_par_en  = 1'b0;
  assign w_par_bit = 1'b0;
  assign w_ctrl_rd = {2'b00, r_im, r_en};
`endif

  // FSM state register; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, bit index, next line level and frame-completion pulse.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_frame_done = 1'b0;
    w_txd_next   = 1'b1;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_START;
      S_START:  if (w_tick) begin
                  w_state_next = S_BITS;
                  w_idx_next   = 3'd0;
                end
      S_BITS:   if (w_tick) begin
                  w_idx_next = r_idx + 3'd1;
                  if (r_idx == 3'd7) w_state_next = w_par_en ? S_PARITY : S_STOP;
                end
      S_PARITY: if (w_tick) w_state_next = S_STOP;
      S_STOP:   if (w_tick) begin
                  w_state_next = S_IDLE;
                  w_frame_done = 1'b1;
                end
      default:  w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_BITS:   w_txd_next = r_data[w_idx_next];
      S_PARITY: w_txd_next = w_par_bit;
      default:  w_txd_next = 1'b1;
    endcase
  end

  // CPU-visible registers and the sticky DONE flag (set beats W1C clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= 8'h00;
      r_en      <= 1'b0;
      r_im      <= 1'b0;
      r_done    <= 1'b0;
      r_divisor <= DIV_RST;
    end else begin
      if (w_accept) r_data <= bus.wdata[7:0];
      if (w_ctrl_wr) begin
        r_en <= bus.wdata[0];
        r_im <= bus.wdata[1];
      end
      r_divisor <= (r_divisor & ~w_div_mask) | (bus.wdata[DIV_WIDTH-1:0] & w_div_mask);
      if (w_frame_done) r_done <= 1'b1;
      else if (w_w1c)   r_done <= 1'b0;
    end
  end

  // Bit timer counts div-1 down to 0, then reloads from the latched divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= DIV_ONE;
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_txd <= 1'b1;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_div <= w_div_eff;
          r_cnt <= w_div_eff - DIV_ONE;
        end
      end else if (w_tick) begin
        r_cnt <= r_div - DIV_ONE;
      end else begin
        r_cnt <= r_cnt - DIV_ONE;
      end
      r_idx <= w_idx_next;
      r_txd <= w_txd_next;
    end
  end

  assign TxD       = r_txd;
  assign bus.HWInt = r_done & r_im;

  // Read mux: combinational, no side effects.
  always_comb begin
    w_div32 = '0;
    w_div32[DIV_WIDTH-1:0] = r_divisor;
    case (w_sel)
      2'd0:    bus.rdata = {24'h0, r_data};
      2'd1:    bus.rdata = {28'h0, w_ctrl_rd};
      2'd2:    bus.rdata = {30'h0, r_done, (r_state != S_IDLE)};
      default: bus.rdata = w_div32;
    endcase
  end

  // Address and data bits outside the decoded fields are intentionally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, bus.Addr, bus.wdata, bus.byteen};

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev.
module tb_uart_tx_dev;
  logic clk = 1'b0;
  logic reset;
  logic TxD;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] rd;

  uart_tx_dev_if bus_if();

  uart_tx_dev #(.DIV_WIDTH(16), .DIV_RESET(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .TxD   (TxD)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    bus_if.Addr   = a;
    bus_if.byteen = be;
    bus_if.wdata  = d;
    @(posedge clk);
    #1;
    bus_if.byteen = 4'b0000;
    $display("write addr=%h be=%b data=%h", a, be, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.Addr   = a;
    bus_if.byteen = 4'b0000;
    #1;
    d = bus_if.rdata;
    $display("read  addr=%h data=%h", a, d);
  endtask

  // Call right after the accepting write returns. bits[i] is the i-th bit on the line.
  task automatic frame_check(input string tag, input logic [10:0] bits, input int nbits,
                             input int div, input bit inject);
    int cyc;
    bus_if.Addr = 32'h8;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        cyc = b * div + c;
        @(negedge clk);
        check_eq($sformatf("%s txd bit%0d cyc%0d", tag, b, cyc), {31'h0, TxD}, {31'h0, bits[b]});
        if (bus_if.Addr[3:2] == 2'd2)
          check_eq($sformatf("%s busy cyc%0d", tag, cyc), {31'h0, bus_if.rdata[0]}, 32'h1);
        if (inject) begin
          case (cyc)
            5: begin bus_if.Addr = 32'h0; bus_if.byteen = 4'b0001; bus_if.wdata = 32'h3C; end
            6: begin bus_if.Addr = 32'hC; bus_if.byteen = 4'b0011; bus_if.wdata = 32'h2; end
            7: begin bus_if.Addr = 32'h8; bus_if.byteen = 4'b0000; end
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    bus_if.Addr = 32'h8;
    #1;
    check_eq({tag, " status after"}, bus_if.rdata, 32'h2);
    check_eq({tag, " txd idle"}, {31'h0, TxD}, 32'h1);
    $display("frame %s bits=%0d div=%0d done", tag, nbits, div);
  endtask

  task automatic check_reset_regs(input string tag);
    bus_read(32'h0, rd); check_eq({tag, " DATA"},    rd, 32'h0);
    bus_read(32'h4, rd); check_eq({tag, " CTRL"},    rd, 32'h0);
    bus_read(32'h8, rd); check_eq({tag, " STATUS"},  rd, 32'h0);
    bus_read(32'hC, rd); check_eq({tag, " DIVISOR"}, rd, 32'h10);
    check_eq({tag, " TxD"},   {31'h0, TxD}, 32'h1);
    check_eq({tag, " HWInt"}, {31'h0, bus_if.HWInt}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.Addr = '0; bus_if.byteen = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_regs("reset");

    // First 0xA5 frame at 4 cycles per bit, then interrupt and W1C.
    bus_write(32'hC, 4'b0011, 32'h4);
    bus_write(32'h4, 4'b0001, 32'h3);
    bus_write(32'h0, 4'b0001, 32'h000000A5);
    frame_check("a5", 11'b00_1101001010, 10, 4, 1'b0);
    check_eq("hwint set", {31'h0, bus_if.HWInt}, 32'h1);
    bus_write(32'h8, 4'b0001, 32'h2);
    bus_read(32'h8, rd); check_eq("w1c status", rd, 32'h0);
    check_eq("w1c hwint", {31'h0, bus_if.HWInt}, 32'h0);

    // Mid-frame DATA write ignored; mid-frame DIVISOR write deferred.
    bus_write(32'h0, 4'b0001, 32'h000000A5);
    frame_check("a5 inject", 11'b00_1101001010, 10, 4, 1'b1);
    bus_read(32'h0, rd); check_eq("data kept", rd, 32'hA5);
    bus_read(32'hC, rd); check_eq("div mid write", rd, 32'h2);

    // Next frame uses the new divisor.
    bus_write(32'h0, 4'b0001, 32'h0000005A);
    frame_check("5a div2", 11'b00_1010110100, 10, 2, 1'b0);

    // Writes that must not start a frame.
    bus_write(32'h4, 4'b0001, 32'h2);
    bus_write(32'h0, 4'b0001, 32'h11);
    repeat (3) @(negedge clk);
    bus_read(32'h8, rd); check_eq("en0 status", rd, 32'h2);
    bus_read(32'h0, rd); check_eq("en0 data", rd, 32'h5A);
    bus_write(32'h4, 4'b0001, 32'h3);
    bus_write(32'h0, 4'b0010, 32'h1100);
    repeat (3) @(negedge clk);
    bus_read(32'h8, rd); check_eq("lane1 status", rd, 32'h2);
    bus_read(32'h0, rd); check_eq("lane1 data", rd, 32'h5A);
    check_eq("no frame txd", {31'h0, TxD}, 32'h1);

    // Partial DIVISOR lane writes.
    bus_write(32'hC, 4'b0011, 32'h10);
    bus_write(32'hC, 4'b0010, 32'h0100);
    bus_read(32'hC, rd); check_eq("div lane1", rd, 32'h110);
    bus_write(32'hC, 4'b1100, 32'hFFFF0000);
    bus_read(32'hC, rd); check_eq("div upper lanes", rd, 32'h110);

    // Reset 13 cycles into a 0xF0 frame (bit b2 = 0 is on the line).
    bus_write(32'hC, 4'b0011, 32'h4);
    bus_write(32'h0, 4'b0001, 32'hF0);
    repeat (13) @(negedge clk);
    check_eq("pre-reset txd", {31'h0, TxD}, 32'h0);
    check_eq("pre-reset hwint", {31'h0, bus_if.HWInt}, 32'h1);
    #1 reset = 1'b1;
    #1 check_eq("async reset txd", {31'h0, TxD}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    check_reset_regs("mid reset");

    // Divisor 0 behaves as 1: 10-cycle frame.
    bus_write(32'hC, 4'b0011, 32'h0);
    bus_write(32'h4, 4'b0001, 32'h1);
    bus_write(32'h0, 4'b0001, 32'hFF);
    frame_check("ff div0", 11'b00_1111111110, 10, 1, 1'b0);
    check_eq("masked hwint", {31'h0, bus_if.HWInt}, 32'h0);

`ifdef UART_TX_PARITY_EN
    bus_write(32'hC, 4'b0011, 32'h2);
    bus_write(32'h4, 4'b0001, 32'h7);
    bus_write(32'h0, 4'b0001, 32'hA5);
    frame_check("a5 even", 11'b10_101001010, 11, 2, 1'b0);
    bus_write(32'h4, 4'b0001, 32'hF);
    bus_read(32'h4, rd); check_eq("ctrl pen podd", rd, 32'hF);
    bus_write(32'h0, 4'b0001, 32'hA5);
    frame_check("a5 odd", 11'b11_101001010, 11, 2, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
